key_event_queue: RTL and testbench

- Input stage directly upstream of the peripheral read mux at $00ff. It replaces the raw key-change latch.
- Synchronises and debounces the four active-low pushbuttons KEY[3:0], then detects press edges.
- Encodes each press as a snake ASCII code and queues the codes in a small FIFO.
- The CPU drains one code per read of $00ff. When the queue is empty, the last consumed code stays presented.

---
 rtl/key_pkg.sv | 24 ++
 rtl/key_debounce.sv | 48 ++++
 rtl/key_event_queue.sv | 113 +++++++++++
 tb/tb_key_event_queue.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/key_pkg.sv
// Shared definitions for the key event queue: key count and key-to-code map.
package key_pkg;

    localparam int NUM_KEYS  = 4;
    localparam int KEY_IDX_W = 2;

    localparam logic [7:0] KEY_CODE_D = 8'h64;
    localparam logic [7:0] KEY_CODE_S = 8'h73;
    localparam logic [7:0] KEY_CODE_W = 8'h77;
    localparam logic [7:0] KEY_CODE_A = 8'h61;

    // Map a key index to the snake-game ASCII code it produces.
    function automatic logic [7:0] key_code_of(input logic [KEY_IDX_W-1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = KEY_CODE_D;
            2'd1:    code = KEY_CODE_S;
            2'd2:    code = KEY_CODE_W;
            default: code = KEY_CODE_A;
        endcase
        return code;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// One pushbutton: two-flop synchroniser, counter debounce, one-cycle press pulse.
module key_debounce #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 16
) (
    input  logic clock,
    input  logic nreset,
    input  logic key_n,
    output logic debounced,
    output logic press
);

    logic             sync_p0;
    logic             sync_p1;
    logic [CNT_W-1:0] cnt;
    logic             deb_p2;
    logic             deb_p3;

    assign debounced = deb_p2;

    // Synchronise, debounce, and register a pulse one edge after a 1->0 flip.
    always_ff @(negedge clock) begin
        if (nreset) begin
            sync_p0 <= 1'b1;
            sync_p1 <= 1'b1;
            cnt     <= '0;
            deb_p2  <= 1'b1;
            deb_p3  <= 1'b1;
            press   <= 1'b0;
        end else begin
            sync_p0 <= key_n;
            sync_p1 <= sync_p0;
            // Debounce stage: the level must disagree for DEBOUNCE_CYCLES edges in a row.
            if (sync_p1 == deb_p2) begin
                cnt <= '0;
            end else if (cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                deb_p2 <= sync_p1;
                cnt    <= '0;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
            // Press stage: releases (0->1) are ignored.
            deb_p3 <= deb_p2;
            press  <= deb_p3 & ~deb_p2;
        end
    end

endmodule

// File: rtl/key_event_queue.sv
// Debounced pushbutton presses, encoded as ASCII and queued for CPU reads of $00ff.
module key_event_queue
    import key_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 16,
    parameter int         CNT_W           = 16,
    parameter int         FIFO_DEPTH      = 4,
    parameter logic [7:0] RESET_CODE      = 8'h73
) (
    input  logic                          clock,
    input  logic                          nreset,
    input  logic [3:0]                    keys,
    input  logic                          rd_strobe,
    output logic [7:0]                    key_code,
    output logic                          key_valid,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow,
    output logic [3:0]                    debounced
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int CNT_OUT_W = PTR_W + 1;

    logic [NUM_KEYS-1:0]  press;
    logic [NUM_KEYS-1:0]  pending;
    logic [NUM_KEYS-1:0]  req;
    logic [NUM_KEYS-1:0]  pending_nxt;
    logic [KEY_IDX_W-1:0] push_idx;
    logic                 push_any;
    logic                 push;
    logic                 pop;
    logic                 full;
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [CNT_OUT_W-1:0] count;
    logic [7:0]           last_code;
    logic [7:0]           mem [FIFO_DEPTH];

    for (genvar i = 0; i < NUM_KEYS; i++) begin : g_key
        key_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W          (CNT_W)
        ) u_debounce (
            .clock    (clock),
            .nreset   (nreset),
            .key_n    (keys[i]),
            .debounced(debounced[i]),
            .press    (press[i])
        );
    end

    assign fifo_count = count;
    assign key_valid  = (count != '0);
    assign key_code   = key_valid ? mem[rd_ptr] : last_code;

    // Arbitrate: a fresh press joins the pending set the same edge, lowest index wins.
    always_comb begin
        req         = pending | press;
        push_idx    = '0;
        push_any    = 1'b0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (req[i]) begin
                push_idx = KEY_IDX_W'(i);
                push_any = 1'b1;
            end
        end
        pop         = rd_strobe && key_valid;
        full        = (count == CNT_OUT_W'(FIFO_DEPTH));
        // A pop in the same cycle frees the slot the push needs.
        push        = push_any && (!full || pop);
        pending_nxt = req;
        if (push) begin
            pending_nxt[push_idx] = 1'b0;
        end
    end

    // Queue control: pointers, occupancy, pending presses, sticky overflow.
    always_ff @(negedge clock) begin
        if (nreset) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            pending   <= '0;
            overflow  <= 1'b0;
            last_code <= RESET_CODE;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                last_code <= mem[rd_ptr];
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_OUT_W'(1);
                2'b01:   count <= count - CNT_OUT_W'(1);
                default: count <= count;
            endcase
            pending <= pending_nxt;
            if ((press & pending) != '0) begin
                overflow <= 1'b1;
            end
        end
    end

    // Queue storage: data only, never reset.
    always_ff @(negedge clock) begin
        if (push) begin
            mem[wr_ptr] <= key_code_of(push_idx);
        end
    end

endmodule

// File: tb/tb_key_event_queue.sv
// Directed bench for key_event_queue with DEBOUNCE_CYCLES=4, FIFO_DEPTH=4.
module tb_key_event_queue;

    logic       clock;
    logic       nreset;
    logic [3:0] keys;
    logic       rd_strobe;
    logic [7:0] key_code;
    logic       key_valid;
    logic [2:0] fifo_count;
    logic       overflow;
    logic [3:0] debounced;

    int n_total = 0;
    int n_bad   = 0;

    key_event_queue #(
        .DEBOUNCE_CYCLES(4),
        .CNT_W          (16),
        .FIFO_DEPTH     (4),
        .RESET_CODE     (8'h73)
    ) dut (
        .clock     (clock),
        .nreset    (nreset),
        .keys      (keys),
        .rd_strobe (rd_strobe),
        .key_code  (key_code),
        .key_valid (key_valid),
        .fifo_count(fifo_count),
        .overflow  (overflow),
        .debounced (debounced)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // DUT updates on negedge; the bench samples and drives on posedge.
    task automatic tick(input int n = 1);
        repeat (n) @(posedge clock);
    endtask

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic read_pulse();
        rd_strobe = 1'b1;
        tick();
        rd_strobe = 1'b0;
    endtask

    task automatic press_key(input int idx);
        keys[idx] = 1'b0;
        tick(10);
        keys[idx] = 1'b1;
        tick(10);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!key_valid && n < 16) begin
            tick();
            n++;
        end
    endtask

    logic [7:0] sim_codes [4] = '{8'h64, 8'h73, 8'h77, 8'h61};
    logic [7:0] full_codes[4] = '{8'h77, 8'h64, 8'h77, 8'h73};

    initial begin
        int lat;
        nreset    = 1'b1;
        keys      = 4'hF;
        rd_strobe = 1'b0;
        tick(3);

        // Reset state
        chk("rst_code",  32'(key_code),   32'h73);
        chk("rst_valid", 32'(key_valid),  32'h0);
        chk("rst_count", 32'(fifo_count), 32'h0);
        chk("rst_ovf",   32'(overflow),   32'h0);
        chk("rst_deb",   32'(debounced),  32'hF);
        nreset = 1'b0;
        tick(2);

        // Single press of key0: 2 sync + 4 debounce + press + push = 8 edges
        keys[0] = 1'b0;
        wait_valid(lat);
        chk("single_lat",   32'(lat),        32'd8);
        chk("single_code",  32'(key_code),   32'h64);
        chk("single_count", 32'(fifo_count), 32'd1);
        chk("single_deb",   32'(debounced),  32'hE);
        tick(20 - lat);
        keys[0] = 1'b1;
        tick(12);
        chk("release_count", 32'(fifo_count), 32'd1);
        read_pulse();
        chk("pop_valid", 32'(key_valid),  32'h0);
        chk("pop_code",  32'(key_code),   32'h64);
        chk("pop_count", 32'(fifo_count), 32'd0);
        read_pulse();
        chk("empty_rd_code",  32'(key_code),   32'h64);
        chk("empty_rd_count", 32'(fifo_count), 32'd0);

        // Bounce on key2: 2-cycle pulses never satisfy a 4-cycle debounce
        for (int i = 0; i < 8; i++) begin
            keys[2] = i[0];
            tick(2);
        end
        keys[2] = 1'b1;
        tick(12);
        chk("bounce_deb",   32'(debounced),  32'hF);
        chk("bounce_count", 32'(fifo_count), 32'd0);
        chk("bounce_valid", 32'(key_valid),  32'h0);

        // Simultaneous press: one push per cycle in key order
        keys = 4'h0;
        wait_valid(lat);
        chk("sim_lat", 32'(lat), 32'd8);
        chk("sim_count1", 32'(fifo_count), 32'd1);
        for (int k = 2; k <= 4; k++) begin
            tick();
            chk("sim_count_step", 32'(fifo_count), 32'(k));
        end
        tick(4);
        chk("sim_count_hold", 32'(fifo_count), 32'd4);
        chk("sim_ovf",        32'(overflow),   32'h0);
        keys = 4'hF;
        tick(12);
        for (int k = 0; k < 4; k++) begin
            chk("sim_head", 32'(key_code), 32'(sim_codes[k]));
            read_pulse();
            chk("sim_drain_count", 32'(fifo_count), 32'(3 - k));
        end
        chk("sim_last_code", 32'(key_code),  32'h61);
        chk("sim_empty",     32'(key_valid), 32'h0);

        // Full queue, then key1 twice: first waits pending, second merges
        press_key(3);
        press_key(2);
        press_key(0);
        press_key(2);
        chk("full_count", 32'(fifo_count), 32'd4);
        chk("full_ovf0",  32'(overflow),   32'h0);
        press_key(1);
        chk("pend_count", 32'(fifo_count), 32'd4);
        chk("pend_ovf",   32'(overflow),   32'h0);
        press_key(1);
        chk("merge_count", 32'(fifo_count), 32'd4);
        chk("merge_ovf",   32'(overflow),   32'h1);
        chk("full_head",   32'(key_code),   32'h61);
        read_pulse();
        chk("pushpop_count", 32'(fifo_count), 32'd4);
        for (int k = 0; k < 4; k++) begin
            chk("full_drain_head", 32'(key_code), 32'(full_codes[k]));
            read_pulse();
        end
        chk("full_drain_count", 32'(fifo_count), 32'd0);
        chk("full_last_code",   32'(key_code),   32'h73);
        chk("full_ovf_sticky",  32'(overflow),   32'h1);

        // Reset with three queued codes
        press_key(0);
        press_key(2);
        press_key(3);
        chk("pre_rst_count", 32'(fifo_count), 32'd3);
        nreset = 1'b1;
        tick();
        chk("midrst_count", 32'(fifo_count), 32'd0);
        chk("midrst_code",  32'(key_code),   32'h73);
        chk("midrst_ovf",   32'(overflow),   32'h0);
        chk("midrst_valid", 32'(key_valid),  32'h0);
        nreset = 1'b0;
        tick(12);
        chk("post_rst_count", 32'(fifo_count), 32'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "simulation time limit reached");
    end

endmodule
